// File: rtl/axis_write_data_pkg.sv
// -----------------------------------------------------------------------------
// axis_write_data_pkg
// Shared definitions for the AXI write-data stage:
//   - state_e       : FSM encoding (IDLE / ACTIVE / FLUSH)
//   - clog2_min1()  : ceil(log2(x)), never less than 1, for counter widths
//   - strb_width()  : byte-strobe width of a data bus (data_width / 8)
// -----------------------------------------------------------------------------
package axis_write_data_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Counter width for a power-of-two modulus; clamped to 1 so that a ratio
    // of 1 still yields a legal vector.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Strobe width of the AXI data bus (AXI_DATA_WIDTH / 8).
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_write_fifo.sv
// -----------------------------------------------------------------------------
// axis_write_fifo
// Synchronous FIFO, depth 2**AWIDTH, with a registered read-data output that
// always holds the current head entry (show-ahead).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_wdata (accepted when not full, or when popping)
//   i_wdata    entry to write
//   i_pop      remove head entry (ignored when empty)
//   o_rdata    registered head entry, stable until popped
//   o_full     FIFO holds 2**AWIDTH entries
//   o_empty    FIFO holds no entries
// -----------------------------------------------------------------------------
module axis_write_fifo #(
    parameter int AWIDTH = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic [WIDTH-1:0]  r_rdata;

    logic              w_pop;
    logic              w_push;
    logic [AWIDTH-1:0] w_rd_next;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_rdata;
    assign w_pop     = i_pop & ~o_empty;
    // A pop frees the head slot in the same cycle, so push-while-full is legal.
    assign w_push    = i_push & (~o_full | w_pop);
    assign w_rd_next = r_rd_ptr + PTR_ONE;

    // NOTE: storage array has no reset; validity is tracked by r_count, and
    // leaving it unreset lets synthesis map it to plain flops/RAM without a
    // reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= w_rd_next;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            // Output register tracks the next head entry.
            if (w_pop) begin
                if (r_count != CNT_ONE) r_rdata <= r_mem[w_rd_next];
                else if (w_push)        r_rdata <= i_wdata;
            end else if (w_push && o_empty) begin
                r_rdata <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/axis_write_data.sv
// -----------------------------------------------------------------------------
// axis_write_data
// Write-path data stage: packs WIDTH_RATIO narrow stream words into one
// AXI_DATA_WIDTH beat, queues beats in a 2**BUF_AWIDTH-deep FIFO and drives the
// AXI W channel with per-burst wlast (every BURST_LENGTH beats and on the final
// beat of a transfer).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cfg_length/cfg_val/cfg_rdy transfer length in words (accepted in IDLE)
//   data/valid/ready           narrow input stream
//   axi_wdata/axi_wstrb/
//   axi_wlast/axi_wvalid/
//   axi_wready                 AXI write-data channel
// Build option:
//   AXIS_WRITE_DATA_STRB_EN    when defined, axi_wstrb covers only filled lanes
//                              of a short final beat; otherwise it is all ones.
// -----------------------------------------------------------------------------
module axis_write_data
    import axis_write_data_pkg::*;
#(
    parameter int BUF_AWIDTH     = 4,
    parameter int CFG_DWIDTH     = 32,
    parameter int WIDTH_RATIO    = 8,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LENGTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CFG_DWIDTH-1:0]       cfg_length,
    input  logic                        cfg_val,
    output logic                        cfg_rdy,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        valid,
    output logic                        ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready
);

    localparam int STRB_W   = strb_width(AXI_DATA_WIDTH);
    localparam int WORD_B   = DATA_WIDTH / 8;
    localparam int LANE_W   = clog2_min1(WIDTH_RATIO);
    localparam int BEAT_W   = clog2_min1(BURST_LENGTH);
    localparam int ENTRY_W  = AXI_DATA_WIDTH + STRB_W + 1;

    localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(WIDTH_RATIO - 1);
    localparam logic [LANE_W-1:0]     LANE_ONE  = LANE_W'(1);
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LENGTH - 1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
    localparam logic [CFG_DWIDTH-1:0] WORDS_ONE = CFG_DWIDTH'(1);

    state_e                    r_state;
    logic [CFG_DWIDTH-1:0]     r_words_rem;
    logic [LANE_W-1:0]         r_lane;
    logic [BEAT_W-1:0]         r_beat;
    logic [AXI_DATA_WIDTH-1:0] r_pack;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_xfer;
    logic                      w_last_word;
    logic                      w_push;
    logic                      w_pop;
    logic [AXI_DATA_WIDTH-1:0] w_beat_data;
    logic [STRB_W-1:0]         w_beat_strb;
    logic                      w_beat_last;
    logic [ENTRY_W-1:0]        w_fifo_wdata;
    logic [ENTRY_W-1:0]        w_fifo_rdata;

    assign cfg_rdy     = (r_state == ST_IDLE);
    assign ready       = (r_state == ST_ACTIVE) & ~w_fifo_full;
    assign w_xfer      = valid & ready;
    assign w_last_word = (r_words_rem == WORDS_ONE);
    // A beat closes on its last lane or on the transfer's final word.
    assign w_push      = w_xfer & ((r_lane == LANE_LAST) | w_last_word);
    assign w_beat_last = (r_beat == BEAT_LAST) | w_last_word;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_beat_data = r_pack;
        for (int l = 0; l < WIDTH_RATIO; l++) begin
            if (r_lane == LANE_W'(l)) w_beat_data[l*DATA_WIDTH +: DATA_WIDTH] = data;
        end
    end

`ifdef AXIS_WRITE_DATA_STRB_EN
    // Lanes 0..r_lane are filled when the beat is pushed.
    always_comb begin
        w_beat_strb = '0;
        for (int l = 0; l < WIDTH_RATIO; l++) begin
            if (LANE_W'(l) <= r_lane) w_beat_strb[l*WORD_B +: WORD_B] = '1;
        end
    end
`else
    // Padded lanes are zero in r_pack, so writing them is harmless.
    assign w_beat_strb = '1;
`endif

    assign w_fifo_wdata = {w_beat_data, w_beat_strb, w_beat_last};
    assign axi_wvalid   = ~w_fifo_empty;
    assign w_pop        = axi_wvalid & axi_wready;
    assign {axi_wdata, axi_wstrb, axi_wlast} = w_fifo_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_words_rem <= '0;
            r_lane      <= '0;
            r_beat      <= '0;
            r_pack      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_val) begin
                        r_words_rem <= cfg_length;
                        r_lane      <= '0;
                        r_beat      <= '0;
                        r_pack      <= '0;
                        if (cfg_length != '0) r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_xfer) begin
                        r_words_rem <= r_words_rem - WORDS_ONE;
                        if (w_push) begin
                            r_pack <= '0;
                            r_lane <= '0;
                            r_beat <= r_beat + BEAT_ONE;
                        end else begin
                            r_pack <= w_beat_data;
                            r_lane <= r_lane + LANE_ONE;
                        end
                        if (w_last_word) r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_fifo_empty) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axis_write_fifo #(
        .AWIDTH (BUF_AWIDTH),
        .WIDTH  (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_axis_write_data.sv
// -----------------------------------------------------------------------------
// tb_axis_write_data
// Scoreboard bench for axis_write_data: stimulus pushes expected beats into a
// queue, a monitor pops and compares on every W-channel handshake.
// Strobe expectations follow AXIS_WRITE_DATA_STRB_EN.
// -----------------------------------------------------------------------------
module tb_axis_write_data;

    localparam int WR = 8;
    localparam int BL = 16;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cfg_length;
    logic         cfg_val;
    logic         cfg_rdy;
    logic [31:0]  data;
    logic         valid;
    logic         ready;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;

    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    lasts_seen = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    axis_write_data dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_length (cfg_length),
        .cfg_val    (cfg_val),
        .cfg_rdy    (cfg_rdy),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .axi_wdata  (axi_wdata),
        .axi_wstrb  (axi_wstrb),
        .axi_wlast  (axi_wlast),
        .axi_wvalid (axi_wvalid),
        .axi_wready (axi_wready)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beat b of a transfer of len words whose word i carries base+i.
    function automatic beat_t model_beat(input int base, input int len, input int b);
        beat_t t;
        int    k;
        t.data = '0;
        t.strb = '0;
        k = len - b * WR;
        if (k > WR) k = WR;
        for (int l = 0; l < k; l++) t.data[l*32 +: 32] = 32'(base + b * WR + l);
`ifdef AXIS_WRITE_DATA_STRB_EN
        for (int l = 0; l < k; l++) t.strb[l*4 +: 4] = 4'hF;
`else
        t.strb = '1;
`endif
        t.last = ((b % BL) == BL - 1) || (b == (len + WR - 1) / WR - 1);
        return t;
    endfunction

    task automatic push_model(input int base, input int len);
        for (int b = 0; b < (len + WR - 1) / WR; b++) exp_q.push_back(model_beat(base, len, b));
    endtask

    // Monitor: compare every accepted W beat against the scoreboard head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (axi_wvalid && axi_wready) begin
                beats_seen++;
                if (axi_wlast) lasts_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {224'b0, axi_wdata[31:0]}, 256'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("wdata", axi_wdata, e.data);
                    check("wstrb", {224'b0, axi_wstrb}, {224'b0, e.strb});
                    check("wlast", {255'b0, axi_wlast}, {255'b0, e.last});
                end
            end
        end
    end

    task automatic start_cfg(input int len);
        cfg_length = 32'(len);
        cfg_val    = 1'b1;
        @(posedge clk); #1;
        cfg_val    = 1'b0;
    endtask

    // Drive words base+from .. base+to-1, bounded by max_cyc cycles.
    task automatic feed(input int base, input int from, input int to,
                        input int max_cyc, output int sent);
        int  idx;
        int  cyc;
        logic hs;
        idx = from;
        cyc = 0;
        while (idx < to && cyc < max_cyc) begin
            valid = 1'b1;
            data  = 32'(base + idx);
            @(negedge clk);
            hs = ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        valid = 1'b0;
        sent  = idx;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int c;
        c = 0;
        while (!(cfg_rdy && !axi_wvalid && exp_q.size() == 0) && c < max_cyc) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, {255'b0, (c < max_cyc)}, 256'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int    sent;
        int    b0;
        int    l0;
        beat_t bp0;

        rst = 1'b1; cfg_val = 1'b0; cfg_length = '0;
        data = '0; valid = 1'b0; axi_wready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_cfg_rdy", {255'b0, cfg_rdy},    256'd1);
        check("rst_ready",   {255'b0, ready},      256'd0);
        check("rst_wvalid",  {255'b0, axi_wvalid}, 256'd0);
        check("rst_wlast",   {255'b0, axi_wlast},  256'd0);
        check("rst_wdata",   axi_wdata,            256'd0);
        check("rst_wstrb",   {224'b0, axi_wstrb},  256'd0);

        // Basic packing: 10 words -> two beats (hand-computed)
        axi_wready = 1'b1;
        exp_q.push_back('{data: {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                          strb: 32'hFFFF_FFFF, last: 1'b0});
`ifdef AXIS_WRITE_DATA_STRB_EN
        exp_q.push_back('{data: {192'd0, 32'd10, 32'd9}, strb: 32'h0000_00FF, last: 1'b1});
`else
        exp_q.push_back('{data: {192'd0, 32'd10, 32'd9}, strb: 32'hFFFF_FFFF, last: 1'b1});
`endif
        start_cfg(10);
        feed(1, 0, 10, 100, sent);
        wait_idle("basic_drain", 100);
        check("basic_beats",  256'(beats_seen), 256'd2);
        check("basic_idle",   {255'b0, cfg_rdy}, 256'd1);

        // Burst split: 256 words -> 32 beats, wlast on 15 and 31
        b0 = beats_seen; l0 = lasts_seen;
        push_model(100, 256);
        start_cfg(256);
        feed(100, 0, 256, 600, sent);
        wait_idle("burst_drain", 200);
        check("burst_beats", 256'(beats_seen - b0), 256'd32);
        check("burst_lasts", 256'(lasts_seen - l0), 256'd2);

        // Backpressure: FIFO absorbs 16 beats (128 words) then ready drops
        axi_wready = 1'b0;
        bp0 = model_beat(1000, 200, 0);
        push_model(1000, 200);
        start_cfg(200);
        feed(1000, 0, 200, 160, sent);
        check("bp_words",   256'(sent),           256'd128);
        check("bp_ready",   {255'b0, ready},      256'd0);
        check("bp_wvalid",  {255'b0, axi_wvalid}, 256'd1);
        check("bp_beat0_a", axi_wdata,            bp0.data);
        repeat (5) @(posedge clk);
        #1;
        check("bp_beat0_b", axi_wdata,            bp0.data);
        axi_wready = 1'b1;
        feed(1000, sent, 200, 400, sent);
        check("bp_rest",    256'(sent),           256'd200);
        wait_idle("bp_drain", 100);

        // Zero length: no beats, stays idle
        b0 = beats_seen;
        start_cfg(0);
        repeat (3) @(posedge clk);
        #1;
        check("zero_cfg_rdy", {255'b0, cfg_rdy},    256'd1);
        check("zero_wvalid",  {255'b0, axi_wvalid}, 256'd0);
        check("zero_beats",   256'(beats_seen - b0), 256'd0);

        // Config during ACTIVE is ignored
        b0 = beats_seen;
        push_model(5000, 16);
        start_cfg(16);
        feed(5000, 0, 4, 50, sent);
        check("ign_cfg_rdy", {255'b0, cfg_rdy}, 256'd0);
        start_cfg(5);
        feed(5000, 4, 16, 100, sent);
        wait_idle("ign_drain", 100);
        check("ign_beats", 256'(beats_seen - b0), 256'd2);

        // Reset mid-transfer: beat0 held in FIFO, then discarded
        axi_wready = 1'b0;
        start_cfg(20);
        feed(3000, 0, 12, 100, sent);
        check("mid_words", 256'(sent), 256'd12);
        b0 = beats_seen;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_cfg_rdy", {255'b0, cfg_rdy},    256'd1);
        check("mid_wvalid",  {255'b0, axi_wvalid}, 256'd0);
        check("mid_ready",   {255'b0, ready},      256'd0);
        axi_wready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_stale", 256'(beats_seen - b0), 256'd0);

        // Fresh transfer after reset
        push_model(4000, 8);
        start_cfg(8);
        feed(4000, 0, 8, 50, sent);
        wait_idle("post_rst_drain", 100);
        check("post_rst_beats", 256'(beats_seen - b0), 256'd1);
        check("queue_empty",    256'(exp_q.size()),    256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_write_data.md
# axis_write_data

Write-path data stage for the AXI master: accepts a configured number of narrow stream words, packs WIDTH_RATIO words into one AXI_DATA_WIDTH beat, and drives the AXI W channel with per-burst `axi_wlast`. It mirrors axis_read_data on the write side. It sits between the user stream producer and the AXI write-data channel, beside the write-address stage, which splits bursts by the same BURST_LENGTH rule.

## Interface
- BUF_AWIDTH, 4: log2 depth of the beat FIFO (16 beats)
- CFG_DWIDTH, 32: width of `cfg_length`
- WIDTH_RATIO, 8: stream words per AXI beat; power of two
- AXI_DATA_WIDTH, 256: W channel width; equals WIDTH_RATIO*DATA_WIDTH
- DATA_WIDTH, 32: stream word width; multiple of 8
- BURST_LENGTH, 16: beats per full AXI burst; power of two

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_length  in  CFG_DWIDTH  transfer length in stream words
- cfg_val  in  1  config valid
- cfg_rdy  out  1  config ready
- data  in  DATA_WIDTH  stream word
- valid  in  1  stream valid
- ready  out  1  stream ready
- axi_wdata  out  AXI_DATA_WIDTH  write beat
- axi_wstrb  out  AXI_DATA_WIDTH/8  byte strobes
- axi_wlast  out  1  last beat of burst
- axi_wvalid  out  1  beat valid
- axi_wready  in  1  beat accepted

## Operation
- States: IDLE, ACTIVE, FLUSH.
- IDLE: `cfg_rdy`=1. When `cfg_val` is high, latch `cfg_length` into the words-remaining counter. If it is nonzero, go to ACTIVE; if zero, stay in IDLE and produce no beats.
- ACTIVE: `ready` = ~fifo_full. Each word transfer (`valid & ready`) goes into the pack register lane given by the lane counter. The first word of a beat occupies the least-significant lane.
- A beat is pushed into the FIFO on the edge of its WIDTH_RATIO-th word, or on the edge of the final word of the transfer. The beat is formed from the pack register merged with the incoming word. Unfilled lanes are zero.
- Each FIFO entry holds {wdata, wstrb, wlast}.
  - wlast=1 when the beat counter (mod BURST_LENGTH, zeroed at transfer start) equals BURST_LENGTH-1, or when the beat is the final beat.
- After the final word, go to FLUSH. `ready` is 0 in FLUSH.
- FLUSH: return to IDLE on the edge where the FIFO is empty. Any `cfg_val` outside IDLE is ignored.
- W channel: `axi_wvalid` = FIFO not empty. An entry pops on `axi_wvalid & axi_wready`. Its fields hold stable while stalled.
- Counters are CFG_DWIDTH wide (words remaining), log2(WIDTH_RATIO) wide (lane), and log2(BURST_LENGTH) wide (beat); the lane and beat counters wrap naturally.
- Beats per transfer = ceil(cfg_length/WIDTH_RATIO).

## Timing
- Reset values: `cfg_rdy`=1, `ready`=0, `axi_wvalid`=0, `axi_wlast`=0, `axi_wdata`=0, `axi_wstrb`=0. State=IDLE, FIFO empty, all counters 0.
- IDLE→ACTIVE happens on the `cfg_val` edge, so `ready` can rise in the next cycle.
- Push-to-`axi_wvalid` latency is 1 cycle, because the FIFO output is registered.
- With `axi_wready` held high, throughput is one beat per WIDTH_RATIO words.
- Push and pop in the same cycle are allowed, including while the FIFO is full, but `ready` still reads full that cycle.
- Reset mid-operation discards the pack register and FIFO contents. It returns to IDLE next cycle and no partial beat is emitted.

## Configuration
- AXIS_WRITE_DATA_STRB_EN defined: `axi_wstrb` marks only the bytes of filled lanes. A full beat is all ones; a final beat holding k words has its low k*DATA_WIDTH/8 bits set.
- Undefined: `axi_wstrb` is all ones on every beat, and padded lanes write zeros.

## Structure
- Shared package: state encoding (IDLE/ACTIVE/FLUSH), the log2 helper function, and the strobe-width constant AXI_DATA_WIDTH/8.
- One sub-module: `axis_write_fifo`, a synchronous FIFO with registered output, depth 2^BUF_AWIDTH. It is parameterised by entry width AXI_DATA_WIDTH+AXI_DATA_WIDTH/8+1 and exposes full/empty.

## Test plan
- Basic packing (macro on): `cfg_length`=10; words 1..10, `axi_wready`=1 → two beats are produced.
  - Beat0 = {8,7,…,1}, wstrb all ones, wlast=0.
  - Beat1 = {0×6,10,9}, wstrb=32'h000000FF, wlast=1.
  - FSM returns to IDLE.
- Macro off: same stimulus → beat1 has wstrb=32'hFFFFFFFF and the same data.
- Burst split: `cfg_length`=256 → 32 beats, with wlast high only on beats 15 and 31.
- Backpressure: `cfg_length`=200 with `axi_wready`=0.
  - `ready` drops after exactly 128 words and `axi_wvalid` holds beat0 stable.
  - Raising `axi_wready` drains the beats and the remaining 72 words are accepted.
- Zero length and ignored config:
  - `cfg_length`=0 → no beats and `cfg_rdy` stays 1.
  - `cfg_val` with length 5 during ACTIVE → ignored; beat count is unchanged.
- Reset mid-transfer: `rst` for 1 cycle after 12 of 20 words → next cycle `cfg_rdy`=1, `axi_wvalid`=0 and `ready`=0; no stale beat appears afterwards.
